// File: rtl/reg_array_reader.sv
// reg_array_reader: snapshots an N-word bus on i_start and streams the words out over valid/ready.
// Define READER_BITREV_EN to emit words in bit-reversed index order instead of sequential order.
module reg_array_reader #(
    parameter  int N   = 32,
    parameter  int MSB = 16,
    localparam int IW  = $clog2(N)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [N*MSB-1:0] i_data_in,
    output logic             o_busy,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [MSB-1:0]   o_out_data,
    output logic [IW-1:0]    o_out_index,
    output logic             o_out_last,
    output logic             o_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_stateNext;
    logic [IW-1:0]  r_cnt;
    logic [MSB-1:0] r_shadow [N];

    logic           w_capture;
    logic           w_handshake;
    logic           w_cntLast;
    logic           w_streaming;
    logic [IW-1:0]  w_mapIdx;

    // Sequence position to source word index; the bit-reversed build undoes the FFT's scrambled buffer order.
    function automatic logic [IW-1:0] mapIndex(input logic [IW-1:0] cnt);
`ifdef READER_BITREV_EN
        logic [IW-1:0] rev;
        for (int b = 0; b < IW; b++) begin
            rev[b] = cnt[IW-1-b];
        end
        return rev;
`else
        return cnt;
`endif
    endfunction

    assign w_streaming = (r_state == S_STREAM);
    assign w_capture   = (r_state == S_IDLE) && i_start;
    assign w_handshake = w_streaming && i_out_ready;
    assign w_cntLast   = (r_cnt == IW'(N-1));
    assign w_mapIdx    = mapIndex(r_cnt);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_stateNext = S_STREAM;
                end
            end
            S_STREAM: begin
                if (i_out_ready && w_cntLast) begin
                    w_stateNext = S_DONE;
                end
            end
            S_DONE: begin
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // The snapshot is taken only on an accepted start, so later changes on i_data_in cannot leak into a frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            for (int i = 0; i < N; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_capture) begin
            r_cnt <= '0;
            for (int i = 0; i < N; i++) begin
                r_shadow[i] <= i_data_in[i*MSB +: MSB];
            end
        end else if (w_handshake && !w_cntLast) begin
            r_cnt <= r_cnt + IW'(1);
        end
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_out_valid = w_streaming;
    assign o_done      = (r_state == S_DONE);
    assign o_out_last  = w_streaming && w_cntLast;
    assign o_out_index = w_streaming ? w_mapIdx : '0;
    assign o_out_data  = w_streaming ? r_shadow[w_mapIdx] : '0;

endmodule

// File: tb/tb_reg_array_reader.sv
// tb_reg_array_reader: directed scenarios plus randomized traffic, checked every cycle against a frame-queue model.
// The model follows READER_BITREV_EN the same way the design does.
module tb_reg_array_reader;

    localparam int N   = 32;
    localparam int MSB = 16;
    localparam int IW  = $clog2(N);

`ifdef READER_BITREV_EN
    localparam bit BITREV = 1'b1;
`else
    localparam bit BITREV = 1'b0;
`endif

    typedef struct {
        int             idx;
        logic [MSB-1:0] data;
    } word_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [N*MSB-1:0] dataIn;
    logic             busy;
    logic             outValid;
    logic             outReady;
    logic [MSB-1:0]   outData;
    logic [IW-1:0]    outIndex;
    logic             outLast;
    logic             done;

    int    errors = 0;
    int    checks = 0;
    int    dutWords = 0;
    bit    compareEn = 0;
    int    mPhase = 0;
    word_t mQueue[$];

    reg_array_reader #(.N(N), .MSB(MSB)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_data_in   (dataIn),
        .o_busy      (busy),
        .o_out_valid (outValid),
        .i_out_ready (outReady),
        .o_out_data  (outData),
        .o_out_index (outIndex),
        .o_out_last  (outLast),
        .o_done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int mapIdx(input int k);
        int r;
        r = k;
        if (BITREV) begin
            r = 0;
            for (int b = 0; b < IW; b++) begin
                r = r * 2 + ((k >> b) & 1);
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit st, input bit rdy, input bit rs);
        start    = st;
        outReady = rdy;
        rst      = rs;
    endtask

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic setData(input logic [MSB-1:0] base);
        for (int i = 0; i < N; i++) begin
            dataIn[i*MSB +: MSB] = base + MSB'(i);
        end
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while (!done && n < 100) begin
            cycle();
            n++;
        end
        checkOutput(name, done, 1);
    endtask

    // Outputs are compared mid-cycle; the model then advances using the inputs the next rising edge will sample.
    initial begin
        forever begin
            @(negedge clk);
            if (compareEn) begin
                checkOutput("busy", busy, mPhase != 0);
                checkOutput("valid", outValid, mPhase == 1);
                checkOutput("done", done, mPhase == 2);
                if (mPhase == 1) begin
                    checkOutput("data", outData, mQueue[0].data);
                    checkOutput("index", outIndex, mQueue[0].idx);
                    checkOutput("last", outLast, mQueue.size() == 1);
                end
            end
            if (outValid && outReady) dutWords++;
            if (rst) begin
                mPhase = 0;
                mQueue.delete();
            end else begin
                case (mPhase)
                    0: if (start) begin
                        mQueue.delete();
                        for (int k = 0; k < N; k++) begin
                            word_t w;
                            w.idx  = mapIdx(k);
                            w.data = dataIn[w.idx*MSB +: MSB];
                            mQueue.push_back(w);
                        end
                        mPhase = 1;
                    end
                    1: if (outReady) begin
                        void'(mQueue.pop_front());
                        if (mQueue.size() == 0) mPhase = 2;
                    end
                    default: mPhase = 0;
                endcase
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        applyStimulus(0, 0, 1);
        setData(16'h0000);
        repeat (2) cycle();
        checkOutput("resetValid", outValid, 0);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetDone", done, 0);
        checkOutput("resetData", outData, 0);
        compareEn = 1;
        applyStimulus(0, 1, 0);
        cycle();

        $display("[TB] full-rate frame");
        setData(16'h1000);
        dutWords = 0;
        applyStimulus(1, 1, 0);
        cycle();
        applyStimulus(0, 1, 0);
        checkOutput("word0Data", outData, 16'h1000);
        checkOutput("word0Index", outIndex, 0);
        cycle();
        checkOutput("word1Data", outData, BITREV ? 16'h1010 : 16'h1001);
        checkOutput("word1Index", outIndex, BITREV ? 16 : 1);
        cycle();
        checkOutput("word2Data", outData, BITREV ? 16'h1008 : 16'h1002);
        cycle();
        checkOutput("word3Data", outData, BITREV ? 16'h1018 : 16'h1003);
        checkOutput("word3Index", outIndex, BITREV ? 24 : 3);
        n = 0;
        while (!outLast && n < 40) begin
            cycle();
            n++;
        end
        checkOutput("cyclesToLast", n, 28);
        checkOutput("lastData", outData, 16'h101F);
        checkOutput("lastIndex", outIndex, 31);
        cycle();
        checkOutput("donePulse", done, 1);
        checkOutput("doneValid", outValid, 0);
        checkOutput("frameWords", dutWords, 32);
        cycle();
        checkOutput("doneCleared", done, 0);
        checkOutput("idleBusy", busy, 0);

        $display("[TB] backpressure frame");
        dutWords = 0;
        applyStimulus(1, 1, 0);
        cycle();
        applyStimulus(0, 1, 0);
        repeat (5) cycle();
        applyStimulus(0, 0, 0);
        for (int h = 0; h < 3; h++) begin
            checkOutput("holdData", outData, BITREV ? 16'h1014 : 16'h1005);
            checkOutput("holdIndex", outIndex, BITREV ? 20 : 5);
            if (h < 2) cycle();
        end
        applyStimulus(0, 1, 0);
        cycle();
        checkOutput("resumeData", outData, BITREV ? 16'h100C : 16'h1006);
        waitDone("bpDoneSeen");
        checkOutput("bpFrameWords", dutWords, 32);
        cycle();

        $display("[TB] start while busy and capture isolation");
        dutWords = 0;
        applyStimulus(1, 1, 0);
        cycle();
        applyStimulus(0, 1, 0);
        repeat (10) cycle();
        applyStimulus(1, 1, 0);
        setData(16'hFFFF);
        for (int i = 0; i < N; i++) dataIn[i*MSB +: MSB] = 16'hFFFF;
        cycle();
        applyStimulus(0, 1, 0);
        checkOutput("isolatedData", outData, BITREV ? 16'h101A : 16'h100B);
        waitDone("isoDoneSeen");
        checkOutput("isoFrameWords", dutWords, 32);
        cycle();
        checkOutput("noSecondFrameA", busy, 0);
        cycle();
        checkOutput("noSecondFrameB", outValid, 0);

        $display("[TB] reset mid-frame");
        setData(16'h1000);
        applyStimulus(1, 1, 0);
        cycle();
        applyStimulus(0, 1, 0);
        repeat (12) cycle();
        applyStimulus(0, 1, 1);
        cycle();
        applyStimulus(0, 1, 0);
        checkOutput("midRstValid", outValid, 0);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstLast", outLast, 0);
        checkOutput("midRstIndex", outIndex, 0);
        checkOutput("midRstData", outData, 0);
        setData(16'h2000);
        applyStimulus(1, 1, 0);
        cycle();
        applyStimulus(0, 1, 0);
        checkOutput("newFrameData", outData, 16'h2000);
        checkOutput("newFrameIndex", outIndex, 0);
        waitDone("newDoneSeen");
        cycle();

        $display("[TB] reset and start together");
        applyStimulus(1, 1, 1);
        cycle();
        applyStimulus(0, 1, 0);
        checkOutput("rstStartValid", outValid, 0);
        checkOutput("rstStartBusy", busy, 0);
        cycle();
        checkOutput("rstStartValid2", outValid, 0);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 3000; c++) begin
            applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < N; i++) dataIn[i*MSB +: MSB] = MSB'($urandom);
            end
            cycle();
        end
        applyStimulus(0, 1, 0);
        repeat (40) cycle();
        checkOutput("drainedIdle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_array_reader.md
# reg_array_reader

- Parallel-to-serial unloader for FFT stage results; the read-side counterpart of the addressed register array that loads one word per write.
- Snapshots a flat N×MSB word bus on a start pulse, then streams the words one per accepted cycle over a valid/ready interface, with index, last, and done signals.
- Sits between the FFT32 stage output bus and the serial output/UART path.

## Interface
- N, 32, number of words; power of two, ≥2.
- MSB, 16, word width in bits.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to capture data_in and begin streaming; honoured only in IDLE.
- data_in  in  N*MSB  flat word bus; word i occupies bits [(i+1)*MSB-1 : i*MSB].
- busy  out  1  high in STREAM and DONE.
- out_valid  out  1  out_data/out_index/out_last hold a word.
- out_ready  in  1  downstream accepts the word when high together with out_valid.
- out_data  out  MSB  current word.
- out_index  out  $clog2(N)  source word index of out_data.
- out_last  out  1  current word is the final one of the frame.
- done  out  1  one-cycle pulse after the final word is accepted.

## Operation
- Internal registers:
  - shadow array: N×MSB.
  - sequence counter cnt: $clog2(N) bits.
  - state: IDLE, STREAM, DONE.
- IDLE:
  - When start=1: shadow[i] ← data_in word i for all i, cnt ← 0, go to STREAM.
  - Otherwise hold.
- STREAM:
  - out_valid=1.
  - out_index = map(cnt); out_data = shadow[map(cnt)]; out_last = (cnt == N-1).
  - Handshake (out_valid & out_ready) with cnt<N-1: cnt ← cnt+1.
  - Handshake with cnt==N-1: go to DONE.
  - No handshake: all outputs hold stable. The word and index must not change while valid is waiting.
- DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored in STREAM and DONE; there is no queuing. data_in changes after capture have no effect on the frame.
- Every word is emitted exactly once per frame. No skips, no repeats.
- Reset (any state, including mid-frame):
  - state ← IDLE, cnt ← 0, shadow ← all zero.
  - out_valid=0, out_last=0, done=0, busy=0, out_index=0, out_data=0.
  - A partially streamed frame is abandoned and is not resumed.
- rst and start in the same cycle: rst wins and nothing is captured.

## Timing
- Capture latency: start sampled at edge k gives out_valid=1 with word map(0) from edge k onward, i.e. the first cycle after start.
- With out_ready held high, one word per cycle:
  - The frame occupies N cycles.
  - done is high in cycle N+1 after start.
  - The next start can be accepted in cycle N+2.
- out_valid, out_last, busy and done are registered-state decodes. out_data and out_index are a mux of registered values only, with no combinational path from inputs.
- out_ready has no effect on state outside STREAM.

## Configuration
- READER_BITREV_EN defined:
  - map(cnt) = bit-reversal of cnt over $clog2(N) bits, so words leave in natural frequency order from the bit-reversed FFT buffer.
  - For N=32: cnt 1 gives index 16, cnt 2 gives index 8, cnt 31 gives index 31.
- READER_BITREV_EN undefined: map(cnt) = cnt, i.e. sequential order.
- Handshake, latency and reset behaviour are identical in both builds.

## Test plan
- Sequential streaming (macro off), N=32, MSB=16, word i = 16'h1000+i, start pulsed, out_ready=1:
  - 32 consecutive words 16'h1000..16'h101F with out_index 0..31.
  - out_last only on 16'h101F; done exactly one cycle later.
- Backpressure: out_ready=0 for 3 cycles at cnt=5:
  - out_data holds 16'h1005 and out_index holds 5 for those cycles.
  - Resumes at 16'h1006; total 32 words, none duplicated.
- Start ignored while busy, and capture isolation:
  - Second start pulse at cnt=10, and data_in changed to all 16'hFFFF after capture.
  - The remaining words stay 16'h100A..16'h101F; no second frame.
- Reset mid-frame: rst at cnt=12, then start with word i = 16'h2000+i:
  - The cycle after rst shows all outputs 0 and busy=0.
  - The new frame starts at 16'h2000, index 0.
- Simultaneous rst and start in IDLE: state stays IDLE and out_valid stays 0 on the next cycle.
- Bit-reversed order (macro on), word i = 16'h1000+i:
  - Output sequence begins 16'h1000, 16'h1010, 16'h1008, 16'h1018, with out_index 0, 16, 8, 24.
  - Final word is 16'h101F with out_last=1.
